// File: rtl/axi_resp_demux.sv
// -----------------------------------------------------------------------------
// axi_resp_demux
//
// Return path of the AXI interconnect. The single slave-side response channel
// (R or B style: id/data/resp/last) is routed back to the master port whose
// index the request arbiter prepended to the ID. There is one register stage
// between the slave side and the master side.
//
// Optional outstanding-burst tracking (macro AXI_RESP_DEMUX_TRACK_EN):
//   defined   - per-master burst counters, out_full, and responses arriving
//               for a master with no outstanding burst are dropped.
//   undefined - no counters, out_full tied low, issue_en/issue_idx ignored;
//               only beats whose index is not a valid master are dropped.
//
// Parameters:
//   NUM_MST  number of master ports (>= 2)
//   ID_W     master-side ID width; slave-side ID is {sel, id}
//   DATA_W   response data width (1 for B-channel use)
//   MAX_OUT  maximum outstanding bursts per master
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_valid/s_ready     slave-side response handshake
//   s_id/s_data/s_resp/s_last  slave-side response beat (s_id carries index)
//   m_valid/m_ready     per-master handshake, one bit per master
//   m_id/m_data/m_resp/m_last  per-master payload, master k at slice k
//   issue_en/issue_idx  a request burst was granted to master issue_idx
//   out_full            master k has MAX_OUT bursts outstanding
//   err_o               one-cycle pulse after a response beat was dropped
// -----------------------------------------------------------------------------
module axi_resp_demux #(
  parameter int NUM_MST = 4,
  parameter int ID_W    = 4,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 8,
  localparam int SEL_W  = $clog2(NUM_MST),
  localparam int CNT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [SEL_W+ID_W-1:0]     s_id,
  input  logic [DATA_W-1:0]         s_data,
  input  logic [1:0]                s_resp,
  input  logic                      s_last,
  output logic [NUM_MST-1:0]        m_valid,
  input  logic [NUM_MST-1:0]        m_ready,
  output logic [NUM_MST*ID_W-1:0]   m_id,
  output logic [NUM_MST*DATA_W-1:0] m_data,
  output logic [NUM_MST*2-1:0]      m_resp,
  output logic [NUM_MST-1:0]        m_last,
  input  logic                      issue_en,
  input  logic [SEL_W-1:0]          issue_idx,
  output logic [NUM_MST-1:0]        out_full,
  output logic                      err_o
);

  function automatic logic idx_in_range(input logic [SEL_W-1:0] idx);
    return ({1'b0, idx} < (SEL_W + 1)'(NUM_MST));
  endfunction

  logic              vld_p1;
  logic [SEL_W-1:0]  sel_p1;
  logic [ID_W-1:0]   id_p1;
  logic [DATA_W-1:0] data_p1;
  logic [1:0]        resp_p1;
  logic              last_p1;
  logic              err_p1;

  logic [SEL_W-1:0]  sel_p0;
  logic              hs_p0;
  logic              in_range_p0;
  logic              cnt_ok_p0;
  logic              drop_p0;
  logic              load_p0;

  // ---- Stage p0: slave-side handshake and drop decision ----
  assign sel_p0      = s_id[SEL_W+ID_W-1 -: SEL_W];
  // The held beat only blocks the slave side while its own master stalls.
  assign s_ready     = !vld_p1 || m_ready[sel_p1];
  assign hs_p0       = s_valid && s_ready;
  assign in_range_p0 = idx_in_range(sel_p0);
  // A dropped beat is still accepted upstream, it just never enters the register.
  assign drop_p0     = hs_p0 && !(in_range_p0 && cnt_ok_p0);
  assign load_p0     = hs_p0 && !drop_p0;

`ifdef AXI_RESP_DEMUX_TRACK_EN
  logic [CNT_W-1:0]   cnt_p1  [NUM_MST];
  logic [CNT_W-1:0]   cnt_nxt [NUM_MST];
  logic [NUM_MST-1:0] full_p1;

  // Saturating up/down step; a simultaneous issue and completion cancel out.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                input logic inc,
                                                input logic dec);
    logic [CNT_W-1:0] r;
    r = cnt;
    if (inc && !dec) begin
      if (cnt != CNT_W'(MAX_OUT)) r = cnt + 1'b1;
    end else if (dec && !inc) begin
      r = cnt - 1'b1;
    end
    return r;
  endfunction

  // Only indexed when in range; the && keeps an out-of-range read harmless.
  assign cnt_ok_p0 = in_range_p0 && (cnt_p1[sel_p0] != '0);

  // Completion is counted when the last beat is captured, not when delivered.
  always_comb begin
    for (int k = 0; k < NUM_MST; k++) begin
      cnt_nxt[k] = cnt_step(cnt_p1[k],
                            issue_en && (issue_idx == SEL_W'(k)),
                            load_p0 && s_last && (sel_p0 == SEL_W'(k)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_MST; k++) cnt_p1[k] <= '0;
      full_p1 <= '0;
    end else begin
      for (int k = 0; k < NUM_MST; k++) begin
        cnt_p1[k]  <= cnt_nxt[k];
        full_p1[k] <= (cnt_nxt[k] == CNT_W'(MAX_OUT));
      end
    end
  end

  assign out_full = full_p1;
`else
  logic unused_issue;

  assign cnt_ok_p0    = 1'b1;
  assign out_full     = '0;
  assign unused_issue = ^{issue_en, issue_idx};
`endif

  // ---- Stage p1: single holding register toward the masters ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      sel_p1  <= '0;
      id_p1   <= '0;
      data_p1 <= '0;
      resp_p1 <= '0;
      last_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      err_p1 <= drop_p0;
      if (load_p0) begin
        vld_p1  <= 1'b1;
        sel_p1  <= sel_p0;
        id_p1   <= s_id[ID_W-1:0];
        data_p1 <= s_data;
        resp_p1 <= s_resp;
        last_p1 <= s_last;
      end else if (vld_p1 && m_ready[sel_p1]) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  // Payload is broadcast on every slice; only the selected valid is raised.
  always_comb begin
    m_valid = '0;
    m_id    = '0;
    m_data  = '0;
    m_resp  = '0;
    m_last  = '0;
    for (int k = 0; k < NUM_MST; k++) begin
      m_valid[k]                = vld_p1 && (sel_p1 == SEL_W'(k));
      m_id[k*ID_W +: ID_W]      = id_p1;
      m_data[k*DATA_W +: DATA_W] = data_p1;
      m_resp[k*2 +: 2]          = resp_p1;
      m_last[k]                 = last_p1;
    end
  end

  assign err_o = err_p1;

endmodule

// File: tb/tb_axi_resp_demux.sv
module tb_axi_resp_demux;

  localparam int NUM_MST = 4;
  localparam int ID_W    = 4;
  localparam int DATA_W  = 32;
  localparam int MAX_OUT = 8;
  localparam int SEL_W   = 2;

`ifdef AXI_RESP_DEMUX_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  sel;
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic                      clk;
  logic                      rst_n;
  logic                      s_valid;
  logic                      s_ready;
  logic [SEL_W+ID_W-1:0]     s_id;
  logic [DATA_W-1:0]         s_data;
  logic [1:0]                s_resp;
  logic                      s_last;
  logic [NUM_MST-1:0]        m_valid;
  logic [NUM_MST-1:0]        m_ready;
  logic [NUM_MST*ID_W-1:0]   m_id;
  logic [NUM_MST*DATA_W-1:0] m_data;
  logic [NUM_MST*2-1:0]      m_resp;
  logic [NUM_MST-1:0]        m_last;
  logic                      issue_en;
  logic [SEL_W-1:0]          issue_idx;
  logic [NUM_MST-1:0]        out_full;
  logic                      err_o;

  axi_resp_demux #(
    .NUM_MST(NUM_MST), .ID_W(ID_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_id(s_id), .s_data(s_data),
    .s_resp(s_resp), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_id(m_id), .m_data(m_data),
    .m_resp(m_resp), .m_last(m_last),
    .issue_en(issue_en), .issue_idx(issue_idx),
    .out_full(out_full), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: one held beat, outstanding count per master, error flag.
  bit    mv;
  beat_t mb;
  int    cnt [NUM_MST];
  bit    merr;
  beat_t src_q [$];
  bit    obs_rdy;
  bit    obs_dlv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mv   = 1'b0;
    mb   = '0;
    merr = 1'b0;
    for (int k = 0; k < NUM_MST; k++) cnt[k] = 0;
  endtask

  task automatic load_src();
    if (src_q.size() > 0) begin
      s_valid = 1'b1;
      s_id    = {src_q[0].sel, src_q[0].id};
      s_data  = src_q[0].data;
      s_resp  = src_q[0].resp;
      s_last  = src_q[0].last;
    end else begin
      s_valid = 1'b0;
    end
  endtask

  task automatic push(input logic [1:0] sel, input logic [3:0] id,
                      input logic [31:0] data, input logic [1:0] resp, input logic last);
    beat_t b;
    b.sel = sel; b.id = id; b.data = data; b.resp = resp; b.last = last;
    src_q.push_back(b);
    if (src_q.size() == 1) load_src();
  endtask

  // One clock cycle: compare DUT against the model, advance the model by the
  // rules (accept, drop, deliver, count), then step the clock.
  task automatic cyc();
    bit                 exp_rdy, hs, drop, dlv, inc, dec;
    int                 sel_in;
    logic [NUM_MST-1:0] exp_full;
    #1;
    exp_rdy = !mv || m_ready[mb.sel];
    obs_rdy = s_ready;
    obs_dlv = |(m_valid & m_ready);
    chk("cyc_s_ready", s_ready, exp_rdy);
    chk("cyc_m_valid", m_valid, mv ? (4'b0001 << mb.sel) : 4'b0000);
    chk("cyc_err_o", err_o, merr);
    for (int k = 0; k < NUM_MST; k++) exp_full[k] = TRACK && (cnt[k] == MAX_OUT);
    chk("cyc_out_full", out_full, exp_full);
    if (mv) begin
      for (int k = 0; k < NUM_MST; k++)
        chk("cyc_payload", {m_id[k*4 +: 4], m_data[k*32 +: 32], m_resp[k*2 +: 2], m_last[k]},
            {mb.id, mb.data, mb.resp, mb.last});
    end
    sel_in = int'(s_id[5:4]);
    hs     = s_valid && exp_rdy;
    drop   = hs && (sel_in >= NUM_MST || (TRACK && cnt[sel_in] == 0));
    dlv    = mv && m_ready[mb.sel];
    for (int k = 0; k < NUM_MST; k++) begin
      inc = issue_en && (int'(issue_idx) == k);
      dec = hs && !drop && s_last && (sel_in == k);
      if (inc && !dec)      cnt[k] = (cnt[k] < MAX_OUT) ? cnt[k] + 1 : MAX_OUT;
      else if (dec && !inc) cnt[k] = cnt[k] - 1;
    end
    if (hs && !drop) begin
      mv      = 1'b1;
      mb.sel  = s_id[5:4];
      mb.id   = s_id[3:0];
      mb.data = s_data;
      mb.resp = s_resp;
      mb.last = s_last;
    end else if (dlv) begin
      mv = 1'b0;
    end
    merr = drop;
    @(posedge clk);
    #1;
    issue_en = 1'b0;
    if (hs) void'(src_q.pop_front());
    load_src();
  endtask

  task automatic issue(input logic [1:0] idx);
    issue_en  = 1'b1;
    issue_idx = idx;
    cyc();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   [9:0] dl;
    bit   [7:0] rdy;
    int         start_dlv, guard, n_dlv;

    rst_n = 1'b0; s_valid = 1'b0; s_id = '0; s_data = '0; s_resp = '0; s_last = 1'b0;
    m_ready = '1; issue_en = 1'b0; issue_idx = '0;
    model_reset();

    // Reset state
    #3;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data[63:0], 0);
    chk("rst_m_id", m_id, 0);
    chk("rst_err", err_o, 0);
    chk("rst_out_full", out_full, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_s_ready", s_ready, 1);

    // Routing
    issue(2'd2);
    push(2'd2, 4'h5, 32'hA5A5_0001, 2'b00, 1'b1);
    cyc();
    chk("route_valid", m_valid, 4'b0100);
    chk("route_id", m_id[8 +: 4], 4'h5);
    chk("route_data", m_data[64 +: 32], 32'hA5A5_0001);
    cyc();

    // Backpressure
    issue(2'd1);
    for (int i = 0; i < 4; i++) push(2'd1, 4'h3, 32'hB000_0000 + i, 2'b01, i == 3);
    cyc();
    m_ready = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_hold_ready", s_ready, 0);
      chk("bp_hold_data", m_data[32 +: 32], 32'hB000_0000);
    end
    m_ready = 4'b1111;
    n_dlv = 0;
    guard = 0;
    while ((src_q.size() > 0 || mv) && guard < 20) begin
      cyc();
      n_dlv += int'(obs_dlv);
      guard++;
    end
    chk("bp_delivered", n_dlv, 4);

    // Throughput
    for (int i = 0; i < 4; i++) begin issue(2'd0); issue(2'd3); end
    for (int i = 0; i < 8; i++)
      push((i % 2 == 0) ? 2'd0 : 2'd3, 4'(i), 32'hC000_0000 + i, 2'b00, 1'b1);
    dl = '0;
    rdy = '0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      dl[i] = obs_dlv;
      if (i < 8) rdy[i] = obs_rdy;
    end
    chk("tput_ready", rdy, 8'hFF);
    chk("tput_deliv", dl, 10'b01_1111_1110);

    // Unexpected response: master 3 has nothing outstanding
    push(2'd3, 4'h7, 32'hDEAD_0003, 2'b10, 1'b1);
    cyc();
    chk("unexp_valid", m_valid, TRACK ? 4'b0000 : 4'b1000);
    chk("unexp_err", err_o, TRACK);
    cyc();
    chk("unexp_err_clr", err_o, 0);

    // Counter edges on master 0
    for (int i = 0; i < 8; i++) issue(2'd0);
    chk("full_at8", out_full[0], TRACK);
    issue(2'd0);
    chk("full_sat", out_full[0], TRACK);
    issue_en = 1'b1; issue_idx = 2'd0;
    push(2'd0, 4'h1, 32'hE000_0000, 2'b00, 1'b1);
    cyc();
    chk("full_same_cycle", out_full[0], TRACK);
    push(2'd0, 4'h1, 32'hE000_0001, 2'b00, 1'b1);
    cyc();
    chk("full_release", out_full[0], 0);
    for (int i = 0; i < 7; i++) push(2'd0, 4'h2, 32'hE100_0000 + i, 2'b00, 1'b1);
    guard = 0;
    while (src_q.size() > 0 && guard < 30) begin cyc(); guard++; end
    chk("drain_done", src_q.size(), 0);
    push(2'd0, 4'h3, 32'hE200_0000, 2'b00, 1'b1);
    cyc();
    chk("sat_extra_err", err_o, TRACK);
    cyc();

    // Reset in the middle of operation
    for (int i = 0; i < 3; i++) issue(2'd1);
    issue(2'd2);
    m_ready = 4'b1011;
    push(2'd2, 4'h9, 32'hF000_0002, 2'b00, 1'b1);
    cyc();
    chk("pre_rst_valid", m_valid, 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_full", out_full, 0);
    chk("mid_rst_err", err_o, 0);
    chk("mid_rst_data", m_data[127:64], 0);
    model_reset();
    src_q.delete();
    s_valid = 1'b0;
    m_ready = 4'b1111;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", s_ready, 1);
    push(2'd1, 4'h4, 32'hF100_0001, 2'b00, 1'b1);
    cyc();
    chk("post_rst_cnt_err", err_o, TRACK);
    cyc();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      m_ready   = 4'($urandom);
      issue_en  = ($urandom % 4) == 0;
      issue_idx = 2'($urandom);
      if (src_q.size() == 0 && ($urandom % 3) != 0)
        push(2'($urandom), 4'($urandom), $urandom, 2'($urandom), 1'($urandom));
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
